// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM 5-stage pipeline control path: forwarding selects
// and the write-back control bundle carried D->E->M->W.
package arm_pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic RegWrite;
    logic MemtoReg;
    logic PCSrc;
  } ctrl_bits_t;

  // Memory stage holds the newer value, so it takes priority over write-back.
  function automatic fwd_sel_t fwd_sel(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_MEM;
    else if (hit_w) return FWD_WB;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1 and sticks at all-ones.
module sat_counter #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  output logic [CNTW-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    count <= '0;
    else if (inc && count != '1)  count <= count + CNTW'(1);
  end

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// Hazard/sequencing controller: carries write-back control bits D->E->M->W and
// derives forwarding selects, load-use stall, branch flush and PC-write drain.
module hazard_pipe_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Enable,
  input  logic            RegWriteD,
  input  logic            MemtoRegD,
  input  logic            PCSrcD,
  input  logic            CondExE,
  input  logic            BranchTakenE,
  input  logic [3:0]      RA1D,
  input  logic [3:0]      RA2D,
  input  logic [3:0]      WA3E,
  input  logic [3:0]      Match,
  output logic [1:0]      FowardAE,
  output logic [1:0]      FowardBE,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
  output logic            RegWriteW,
  output logic            MemtoRegW,
  output logic            PCSrcW,
  output logic [CNTW-1:0] StallCnt,
  output logic [CNTW-1:0] FlushCnt
);

  ctrl_bits_t ctrl_d, ctrl_e, ctrl_m, ctrl_w;
  logic       ld_stall, pc_pend;

  assign ctrl_d = {RegWriteD, MemtoRegD, PCSrcD};

  // D->E always loads (bubble on FlushE); E->M->W only move when Enable is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_e <= '0;
      ctrl_m <= '0;
      ctrl_w <= '0;
    end else begin
      ctrl_e <= FlushE ? '0 : ctrl_d;
      if (Enable) begin
        ctrl_m.RegWrite <= ctrl_e.RegWrite & CondExE;
        ctrl_m.MemtoReg <= ctrl_e.MemtoReg;
        ctrl_m.PCSrc    <= ctrl_e.PCSrc & CondExE;
        ctrl_w          <= ctrl_m;
      end
    end
  end

  always_comb begin
    ld_stall = ctrl_e.MemtoReg & ctrl_e.RegWrite & ((RA1D == WA3E) | (RA2D == WA3E));
    pc_pend  = PCSrcD | ctrl_e.PCSrc | ctrl_m.PCSrc;
    StallF   = ld_stall | pc_pend;
    StallD   = ld_stall;
    FlushD   = pc_pend | ctrl_w.PCSrc | BranchTakenE;
    // A taken branch squashes a pending load consumer: E is bubbled either way.
    FlushE   = ld_stall | BranchTakenE;
    FowardAE = fwd_sel(Match[0] & ctrl_m.RegWrite, Match[1] & ctrl_w.RegWrite);
    FowardBE = fwd_sel(Match[2] & ctrl_m.RegWrite, Match[3] & ctrl_w.RegWrite);
  end

  assign RegWriteW = ctrl_w.RegWrite;
  assign MemtoRegW = ctrl_w.MemtoReg;
  assign PCSrcW    = ctrl_w.PCSrc;

  sat_counter #(.CNTW(CNTW)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (StallF),
    .count (StallCnt)
  );

  sat_counter #(.CNTW(CNTW)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (FlushE),
    .count (FlushCnt)
  );

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Bench for hazard_pipe_ctrl: directed scenarios with literal expectations plus
// a cycle-level behavioural model compared against every output on each negedge.
module tb_hazard_pipe_ctrl;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic clk = 1'b0, reset = 1'b1, Enable = 1'b1;
  logic RegWriteD = 0, MemtoRegD = 0, PCSrcD = 0, CondExE = 1, BranchTakenE = 0;
  logic [3:0] RA1D = 0, RA2D = 0, WA3E = 0, Match = 0;
  logic [1:0] FowardAE, FowardBE;
  logic StallF, StallD, FlushD, FlushE, RegWriteW, MemtoRegW, PCSrcW;
  logic [CNTW-1:0] StallCnt, FlushCnt;

  int n_chk = 0, n_fail = 0;

  hazard_pipe_ctrl #(.CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .Enable(Enable),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .CondExE(CondExE), .BranchTakenE(BranchTakenE),
    .RA1D(RA1D), .RA2D(RA2D), .WA3E(WA3E), .Match(Match),
    .FowardAE(FowardAE), .FowardBE(FowardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: stage slots 0=E 1=M 2=W, each {RegWrite, MemtoReg, PCSrc}.
  logic [2:0] st [3];
  int m_sc, m_fc;

  function automatic logic m_ld();
    return st[0][2] && st[0][1] && (RA1D == WA3E || RA2D == WA3E);
  endfunction
  function automatic logic m_pend();
    return PCSrcD || st[0][0] || st[1][0];
  endfunction
  function automatic int m_fwd(input logic hm, input logic hw);
    if (hm && st[1][2]) return 2;
    if (hw && st[2][2]) return 1;
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) st[i] = '0;
      m_sc = 0;
      m_fc = 0;
    end else begin
      logic ld, fe, sf;
      ld = m_ld();
      fe = ld || BranchTakenE;
      sf = ld || m_pend();
      if (sf && m_sc < CMAX) m_sc++;
      if (fe && m_fc < CMAX) m_fc++;
      if (Enable) begin
        st[2] = st[1];
        st[1] = {st[0][2] & CondExE, st[0][1], st[0][0] & CondExE};
      end
      st[0] = fe ? 3'b000 : {RegWriteD, MemtoRegD, PCSrcD};
    end
  end

  always @(negedge clk) begin
    chk("FowardAE", FowardAE, m_fwd(Match[0], Match[1]));
    chk("FowardBE", FowardBE, m_fwd(Match[2], Match[3]));
    chk("StallF", StallF, m_ld() || m_pend());
    chk("StallD", StallD, m_ld());
    chk("FlushD", FlushD, m_pend() || st[2][0] || BranchTakenE);
    chk("FlushE", FlushE, m_ld() || BranchTakenE);
    chk("RegWriteW", RegWriteW, st[2][2]);
    chk("MemtoRegW", MemtoRegW, st[2][1]);
    chk("PCSrcW", PCSrcW, st[2][0]);
    chk("StallCnt", StallCnt, m_sc);
    chk("FlushCnt", FlushCnt, m_fc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pc_run(input logic cond, input int es, input int ef, input int epw);
    int ns, nf, pw;
    ns = 0; nf = 0; pw = -1;
    CondExE = cond;
    PCSrcD  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (StallF) ns++;
      if (FlushD) nf++;
      if (PCSrcW && pw < 0) pw = i;
      tick();
      PCSrcD = 1'b0;
    end
    chk("pc_stall_cycles", ns, es);
    chk("pc_flushd_cycles", nf, ef);
    chk("pc_pcsrcw_cycle", pw, epw);
    CondExE = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_stallcnt", StallCnt, 0);
    chk("rst_fae", FowardAE, 0);

    // Forwarding: M hit, then W hit, then both (M wins)
    RegWriteD = 1; tick();
    RegWriteD = 0; tick();
    Match = 4'b0101; #1;
    chk("fwd_mem_A", FowardAE, 2);
    chk("fwd_mem_B", FowardBE, 2);
    tick();
    Match = 4'b1010; #1;
    chk("fwd_wb_A", FowardAE, 1);
    chk("fwd_wb_B", FowardBE, 1);
    Match = 0;
    RegWriteD = 1; tick(); tick(); tick();
    Match = 4'b0011; #1;
    chk("fwd_both_A", FowardAE, 2);
    Match = 0; RegWriteD = 0;
    tick(); tick(); tick();

    // Load-use stall
    MemtoRegD = 1; RegWriteD = 1; tick();
    MemtoRegD = 0; RegWriteD = 0; WA3E = 4'd2; RA2D = 4'd2; RA1D = 4'd5; #1;
    chk("ld_stallf", StallF, 1);
    chk("ld_stalld", StallD, 1);
    chk("ld_flushe", FlushE, 1);
    chk("ld_flushd", FlushD, 0);
    tick();
    chk("ld_stallf_end", StallF, 0);
    chk("ld_stallcnt", StallCnt, 1);
    chk("ld_flushcnt", FlushCnt, 1);
    WA3E = 0; RA1D = 0; RA2D = 0;

    // Asynchronous reset in the middle of a cycle
    RegWriteD = 1; tick(); tick(); tick();
    chk("pre_rst_rwW", RegWriteW, 1);
    Match = 4'hF; #2;
    reset = 1'b1; #1;
    chk("arst_rwW", RegWriteW, 0);
    chk("arst_fae", FowardAE, 0);
    chk("arst_fbe", FowardBE, 0);
    chk("arst_stallcnt", StallCnt, 0);
    chk("arst_flushcnt", FlushCnt, 0);
    RegWriteD = 0; Match = 0;
    @(posedge clk); #3 reset = 1'b0;
    tick();

    // Taken branch bubbles E
    RegWriteD = 1; tick();
    BranchTakenE = 1; #1;
    chk("br_flushd", FlushD, 1);
    chk("br_flushe", FlushE, 1);
    chk("br_stallf", StallF, 0);
    tick();
    BranchTakenE = 0; #1;
    chk("br_flushe_end", FlushE, 0);
    tick(); chk("br_rwW_pre", RegWriteW, 1);
    tick(); chk("br_rwW_bubble", RegWriteW, 0);
    tick(); chk("br_rwW_post", RegWriteW, 1);
    RegWriteD = 0;
    repeat (3) tick();

    // PC write drain, condition passed and failed
    pc_run(1'b1, 3, 4, 3);
    pc_run(1'b0, 2, 2, -1);

    // Counter saturation, then Enable freeze of W
    PCSrcD = 1; BranchTakenE = 1;
    repeat (20) tick();
    chk("sat_stallcnt", StallCnt, CMAX);
    chk("sat_flushcnt", FlushCnt, CMAX);
    BranchTakenE = 0;
    tick(); tick(); tick();
    chk("frz_pre_pcW", PCSrcW, 1);
    Enable = 0; PCSrcD = 0; RegWriteD = 1;
    repeat (4) tick();
    chk("frz_pcW", PCSrcW, 1);
    chk("frz_rwW", RegWriteW, 0);
    Enable = 1; RegWriteD = 0;
    tick(); chk("thaw_pcW1", PCSrcW, 1);
    tick(); chk("thaw_pcW2", PCSrcW, 0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
